// File: rtl/sys_ctrl_axil_master.sv
// AXI4-Lite master: one command -> STREAM_LEN, FLUSH_LEN, CTRL start/release writes, then STATUS polling until DONE/timeout.
// Latency: 4 write round trips plus polling; one AXI transaction outstanding; response held until rsp_ready.
module sys_ctrl_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int POLL_GAP           = 4,
  parameter int MAX_POLLS          = 1024
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [15:0]                       cmd_stream_len,
  input  logic [15:0]                       cmd_flush_len,
  input  logic                              cmd_clear,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [1:0]                        rsp_status,
  output logic [15:0]                       rsp_polls,
  output logic                              busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_ADDR   = 3'd1;
  localparam logic [2:0] S_WR_RESP   = 3'd2;
  localparam logic [2:0] S_POLL_WAIT = 3'd3;
  localparam logic [2:0] S_RD_ADDR   = 3'd4;
  localparam logic [2:0] S_RD_DATA   = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  localparam logic [15:0] GAP_LIM  = 16'(POLL_GAP);
  localparam logic [15:0] POLL_LIM = 16'(MAX_POLLS);

  logic [2:0]  state;
  logic [1:0]  wi;
  logic [15:0] gap_cnt;
  logic [15:0] stream_q;
  logic [15:0] flush_q;
  logic        clear_q;
  logic [15:0] polls_inc;
  logic        aw_ok;
  logic        w_ok;
  logic        unused_rdata;

  // Write order: STREAM_LEN, FLUSH_LEN, CTRL start, CTRL release (slave starts on bit0 rising edge)
  function automatic logic [AW-1:0] wr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return AW'(4'h8);
      2'd1:    return AW'(4'hC);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] wr_data(input logic [1:0] idx, input logic [15:0] s,
                                            input logic [15:0] f, input logic c);
    case (idx)
      2'd0:    return DW'({16'b0, s});
      2'd1:    return DW'({16'b0, f});
      2'd2:    return DW'({30'b0, c, 1'b1});
      default: return '0;
    endcase
  endfunction

  assign cmd_ready    = (state == S_IDLE) && s_axi_aresetn;
  assign busy         = (state != S_IDLE);
  assign polls_inc    = (rsp_polls == 16'hFFFF) ? rsp_polls : rsp_polls + 16'd1;
  assign aw_ok        = !m_axi_awvalid || m_axi_awready;
  assign w_ok         = !m_axi_wvalid || m_axi_wready;
  assign unused_rdata = ^m_axi_rdata[DW-1:1];

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state         <= S_IDLE;
      wi            <= '0;
      gap_cnt       <= '0;
      stream_q      <= '0;
      flush_q       <= '0;
      clear_q       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= '0;
      rsp_polls     <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            stream_q      <= cmd_stream_len;
            flush_q       <= cmd_flush_len;
            clear_q       <= cmd_clear;
            wi            <= 2'd0;
            rsp_polls     <= '0;
            rsp_status    <= '0;
            m_axi_awaddr  <= wr_addr(2'd0);
            m_axi_wdata   <= wr_data(2'd0, cmd_stream_len, cmd_flush_len, cmd_clear);
            m_axi_wstrb   <= '1;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            state        <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              rsp_status <= 2'd2;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (wi == 2'd3) begin
              gap_cnt <= '0;
              state   <= S_POLL_WAIT;
            end else begin
              wi            <= wi + 2'd1;
              m_axi_awaddr  <= wr_addr(wi + 2'd1);
              m_axi_wdata   <= wr_data(wi + 2'd1, stream_q, flush_q, clear_q);
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= S_WR_ADDR;
            end
          end
        end
        S_POLL_WAIT: begin
          if (gap_cnt >= GAP_LIM) begin
            m_axi_araddr  <= AW'(4'h4);
            m_axi_arvalid <= 1'b1;
            state         <= S_RD_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_polls    <= polls_inc;
            if (m_axi_rresp != 2'b00) begin
              rsp_status <= 2'd2;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (m_axi_rdata[0]) begin
              rsp_status <= 2'd0;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (polls_inc == POLL_LIM) begin
              rsp_status <= 2'd1;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else begin
              gap_cnt <= '0;
              state   <= S_POLL_WAIT;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
